// File: rtl/projectile_ctrl.sv
// ---------------------------------------------------------------------------
// projectile_ctrl
//   Player projectile engine. Spawns shots at the player muzzle, moves them
//   upward on a fixed tick, tests every live bullet against every live enemy
//   hit box, pulses the enemy's collided line once per hit and renders bullet
//   pixels one cycle after the pixel coordinate (aligned with the sprite ROM).
//
//   Build option: PROJ_AUTOFIRE_EN
//     defined     -> holding fire spawns one shot every COOLDOWN cycles
//     not defined -> only a rising edge of fire requests a shot
//
// Ports
//   i_clock        system clock, all state on posedge
//   i_reset        asynchronous, active-low reset
//   i_fire         fire button (synchronous)
//   i_player_x/y   muzzle position (px)
//   i_enemy_pos    per enemy {x[9:0], y[9:0]}, enemy e at [20e+19:20e]
//   i_enemy_dead   per enemy, 1 = excluded from collision tests
//   o_collided     per enemy one-cycle hit pulse
//   i_x, i_y       pixel currently being drawn
//   o_rgb          BULLET_RGB on a bullet pixel, else black (1-cycle latency)
//   o_active       bullet slot valid bitmap
// ---------------------------------------------------------------------------
module projectile_ctrl #(
    parameter int          NUM_BULLETS = 4,
    parameter int          NUM_ENEMIES = 4,
    parameter int          MOVE_PERIOD = 500000,
    parameter int          SPEED       = 4,
    parameter int          COOLDOWN    = 4000000,
    parameter int          BULLET_W    = 2,
    parameter int          BULLET_H    = 6,
    parameter int          ENEMY_W     = 30,
    parameter int          ENEMY_H     = 40,
    parameter logic [23:0] BULLET_RGB  = 24'hFFFF00
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_fire,
    input  logic [9:0]                i_player_x,
    input  logic [9:0]                i_player_y,
    input  logic [20*NUM_ENEMIES-1:0] i_enemy_pos,
    input  logic [NUM_ENEMIES-1:0]    i_enemy_dead,
    output logic [NUM_ENEMIES-1:0]    o_collided,
    input  logic [18:0]               i_x,
    input  logic [18:0]               i_y,
    output logic [23:0]               o_rgb,
    output logic [NUM_BULLETS-1:0]    o_active
);

    localparam int TK_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    // Vertical overlap window: -BULLET_H < by-ey < ENEMY_H
    localparam logic signed [10:0] DY_LO = 11'(-BULLET_H);
    localparam logic signed [10:0] DY_HI = 11'(ENEMY_H);

    logic [TK_W-1:0]        r_tick;
    logic [CD_W-1:0]        r_cooldown;
    logic [NUM_BULLETS-1:0] r_valid;
    logic [9:0]             r_bx [NUM_BULLETS];
    logic [9:0]             r_by [NUM_BULLETS];
    logic [NUM_ENEMIES-1:0] r_collided;
    logic [23:0]            r_rgb;

    logic                   w_tick;
    logic                   w_fire_req;
    logic                   w_spawn;
    logic [NUM_BULLETS-1:0] w_free;
    logic [NUM_BULLETS-1:0] w_first_free;
    logic [NUM_BULLETS-1:0] w_spawn_oh;
    logic [9:0]             w_spawn_y;
    logic [NUM_ENEMIES-1:0] w_ovl  [NUM_BULLETS];
    logic [NUM_ENEMIES-1:0] w_cand [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] w_hit_b;
    logic [NUM_ENEMIES-1:0] w_win_e;
    logic [NUM_BULLETS-1:0] w_pix;

    // ---------------- movement tick ----------------
    assign w_tick = (r_tick == TK_W'(MOVE_PERIOD - 1));

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_tick <= '0;
        end else if (w_tick) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + TK_W'(1);
        end
    end

    // ---------------- fire request ----------------
`ifdef PROJ_AUTOFIRE_EN
    assign w_fire_req = i_fire;
`else
    logic r_fire_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_fire_q <= 1'b0;
        end else begin
            r_fire_q <= i_fire;
        end
    end

    assign w_fire_req = i_fire & ~r_fire_q;
`endif

    // A slot being invalidated this cycle is still marked valid, so it only
    // becomes free for spawning on the edge after it is cleared.
    assign w_free       = ~r_valid;
    assign w_first_free = w_free & (~w_free + NUM_BULLETS'(1));
    assign w_spawn      = w_fire_req & (r_cooldown == '0) & (|w_free);
    assign w_spawn_oh   = w_spawn ? w_first_free : '0;
    assign w_spawn_y    = (i_player_y >= 10'(BULLET_H)) ? (i_player_y - 10'(BULLET_H)) : 10'd0;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cooldown <= '0;
        end else if (w_spawn) begin
            r_cooldown <= CD_W'(COOLDOWN - 1);
        end else if (r_cooldown != '0) begin
            r_cooldown <= r_cooldown - CD_W'(1);
        end
    end

    // ---------------- hit test and render per bullet ----------------
    for (genvar gb = 0; gb < NUM_BULLETS; gb++) begin : g_bul
        for (genvar ge = 0; ge < NUM_ENEMIES; ge++) begin : g_en
            logic [9:0]         w_ex;
            logic [9:0]         w_ey;
            logic [8:0]         w_dx_be;
            logic [8:0]         w_dx_eb;
            logic signed [10:0] w_dy;

            assign w_ex = i_enemy_pos[20*ge+10 +: 10];
            assign w_ey = i_enemy_pos[20*ge +: 10];
            // Horizontal distance wraps at 512 px, same as enemy x movement
            assign w_dx_be = r_bx[gb][8:0] - w_ex[8:0];
            assign w_dx_eb = w_ex[8:0] - r_bx[gb][8:0];
            assign w_dy    = $signed({1'b0, r_by[gb]}) - $signed({1'b0, w_ey});

            // Enemies at x >= 600 are parked off-screen and never hit
            assign w_ovl[gb][ge] = r_valid[gb] & ~i_enemy_dead[ge] & (w_ex < 10'd600)
                                 & ((w_dx_be < 9'(ENEMY_W)) | (w_dx_eb < 9'(BULLET_W)))
                                 & (w_dy > DY_LO) & (w_dy < DY_HI);
        end

        // Each bullet nominates only its lowest-index overlapping enemy
        assign w_cand[gb] = w_ovl[gb] & (~w_ovl[gb] + NUM_ENEMIES'(1));

        logic [18:0] w_px_dx;
        logic [18:0] w_px_dy;

        assign w_px_dx  = i_x - {9'd0, r_bx[gb]};
        assign w_px_dy  = i_y - {9'd0, r_by[gb]};
        assign w_pix[gb] = r_valid[gb] & (w_px_dx < 19'(BULLET_W)) & (w_px_dy < 19'(BULLET_H));
    end

    // Each enemy accepts the lowest-index bullet that nominated it; losers
    // stay alive and are accepted on later cycles, one hit per bullet.
    always_comb begin
        logic v_taken;
        w_hit_b = '0;
        w_win_e = '0;
        v_taken = 1'b0;
        for (int e = 0; e < NUM_ENEMIES; e++) begin
            v_taken = 1'b0;
            for (int b = 0; b < NUM_BULLETS; b++) begin
                if (w_cand[b][e] && !v_taken) begin
                    w_hit_b[b] = 1'b1;
                    w_win_e[e] = 1'b1;
                    v_taken    = 1'b1;
                end
            end
        end
    end

    // ---------------- bullet slots ----------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_valid <= '0;
            for (int b = 0; b < NUM_BULLETS; b++) begin
                r_bx[b] <= '0;
                r_by[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BULLETS; b++) begin
                if (w_spawn_oh[b]) begin
                    r_valid[b] <= 1'b1;
                    r_bx[b]    <= i_player_x;
                    r_by[b]    <= w_spawn_y;
                end else if (r_valid[b]) begin
                    // A hit takes priority over movement on the same cycle
                    if (w_hit_b[b]) begin
                        r_valid[b] <= 1'b0;
                    end else if (w_tick) begin
                        if (r_by[b] < 10'(SPEED)) begin
                            r_valid[b] <= 1'b0;
                        end else begin
                            r_by[b] <= r_by[b] - 10'(SPEED);
                        end
                    end
                end
            end
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_collided <= '0;
            r_rgb      <= '0;
        end else begin
            r_collided <= w_win_e;
            r_rgb      <= (|w_pix) ? BULLET_RGB : 24'h000000;
        end
    end

    assign o_collided = r_collided;
    assign o_rgb      = r_rgb;
    assign o_active   = r_valid;

endmodule

// File: tb/tb_projectile_ctrl.sv
module tb_projectile_ctrl;

    localparam int NB = 4;
    localparam int NE = 4;
    localparam int MP = 4;
    localparam int SP = 4;
    localparam int CD = 8;
    localparam int BW = 2;
    localparam int BH = 6;
    localparam int EW = 30;
    localparam int EH = 40;
    localparam logic [23:0] YEL = 24'hFFFF00;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          fire  = 1'b0;
    logic [9:0]    px    = '0;
    logic [9:0]    py    = '0;
    logic [79:0]   epos;
    logic [3:0]    edead = '0;
    logic [3:0]    col;
    logic [18:0]   x     = 19'd700;
    logic [18:0]   y     = 19'd700;
    logic [23:0]   rgb;
    logic [3:0]    active;

    always #5 clk = ~clk;

    projectile_ctrl #(
        .NUM_BULLETS(NB), .NUM_ENEMIES(NE), .MOVE_PERIOD(MP), .SPEED(SP),
        .COOLDOWN(CD), .BULLET_W(BW), .BULLET_H(BH), .ENEMY_W(EW), .ENEMY_H(EH),
        .BULLET_RGB(YEL)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_fire(fire),
        .i_player_x(px), .i_player_y(py),
        .i_enemy_pos(epos), .i_enemy_dead(edead), .o_collided(col),
        .i_x(x), .i_y(y), .o_rgb(rgb), .o_active(active)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_ticks = 0;

    // Reference model: bullets as plain integer coordinates
    bit          mv  [NB];
    int          mbx [NB];
    int          mby [NB];
    int          mcd;
    int          mtick;
    bit          mfq;
    logic [3:0]  mcol;
    logic [23:0] mrgb;

    function automatic logic [3:0] m_active();
        logic [3:0] a;
        for (int b = 0; b < NB; b++) a[b] = mv[b];
        return a;
    endfunction

    function automatic bit overlaps(int bx, int by, int ex, int ey);
        int dx, dxr, dy;
        dx  = (bx - ex) & 511;
        dxr = (ex - bx) & 511;
        dy  = by - ey;
        return ((dx < EW) || (dxr < BW)) && (dy > -BH) && (dy < EH);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            mv[b] = 0; mbx[b] = 0; mby[b] = 0;
        end
        mcd = 0; mtick = 0; mfq = 0; mcol = '0; mrgb = '0;
    endtask

    task automatic park();
        epos  = {4{10'd600, 10'd0}};
        edead = '0;
    endtask

    // Advance model by one clock using the inputs currently applied, then
    // advance the DUT and return 1 time unit after the edge.
    task automatic step();
        int          cand [NB];
        bit          hitb [NB];
        logic [3:0]  ncol;
        logic [23:0] nrgb;
        bit          tick, req;
        int          slot, ex, ey, dx, dy, xi, yi;
        tick = (mtick == MP - 1);
        for (int b = 0; b < NB; b++) begin
            cand[b] = -1;
            hitb[b] = 0;
            if (mv[b]) begin
                for (int e = 0; e < NE; e++) begin
                    ex = int'(epos[20*e+10 +: 10]);
                    ey = int'(epos[20*e +: 10]);
                    if (cand[b] < 0 && !edead[e] && ex < 600 && overlaps(mbx[b], mby[b], ex, ey))
                        cand[b] = e;
                end
            end
        end
        ncol = '0;
        for (int e = 0; e < NE; e++)
            for (int b = 0; b < NB; b++)
                if (cand[b] == e && !ncol[e]) begin
                    ncol[e] = 1'b1;
                    hitb[b] = 1;
                end
        nrgb = '0;
        xi = int'(x);
        yi = int'(y);
        for (int b = 0; b < NB; b++) begin
            dx = xi - mbx[b];
            dy = yi - mby[b];
            if (mv[b] && dx >= 0 && dx < BW && dy >= 0 && dy < BH) nrgb = YEL;
        end
`ifdef PROJ_AUTOFIRE_EN
        req = fire && (mcd == 0);
`else
        req = fire && !mfq && (mcd == 0);
`endif
        slot = -1;
        for (int b = 0; b < NB; b++) if (!mv[b] && slot < 0) slot = b;
        for (int b = 0; b < NB; b++) begin
            if (mv[b]) begin
                if (hitb[b]) mv[b] = 0;
                else if (tick) begin
                    if (mby[b] < SP) mv[b] = 0;
                    else mby[b] = mby[b] - SP;
                end
            end
        end
        if (req && slot >= 0) begin
            mv[slot]  = 1;
            mbx[slot] = int'(px);
            mby[slot] = (int'(py) >= BH) ? int'(py) - BH : 0;
            mcd = CD - 1;
        end else if (mcd > 0) begin
            mcd = mcd - 1;
        end
        if (tick) begin
            mtick = 0;
            n_ticks++;
        end else begin
            mtick = mtick + 1;
        end
        mfq  = fire;
        mcol = ncol;
        mrgb = nrgb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fire  = 1'b0;
        park();
        x = 19'd700;
        y = 19'd700;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic fire_once();
        fire = 1'b1;
        step();
        fire = 1'b0;
    endtask

    // ---------------------------------------------------------------
    task automatic test_reset();
        park();
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (active !== 4'b0000 || col !== 4'b0000 || rgb !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_async got act=%b col=%b rgb=%h exp 0/0/0", active, col, rgb);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        n_tests++;
        if (active !== 4'b0000 || col !== 4'b0000 || rgb !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_release got act=%b col=%b rgb=%h exp 0/0/0", active, col, rgb);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        px = 10'd50; py = 10'd450;
        for (int i = 0; i < 3; i++) begin
            fire_once();
            repeat (8) step();
        end
        n_tests++;
        if (active !== 4'b0111) begin
            n_fail++;
            $display("FAIL midrun_three got=%b exp=0111", active);
        end
        x = 19'(mbx[0]);
        y = 19'(mby[0]);
        step();
        n_tests++;
        if (rgb !== YEL) begin
            n_fail++;
            $display("FAIL midrun_rgb_before got=%h exp=%h", rgb, YEL);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (active !== 4'b0000 || col !== 4'b0000 || rgb !== 24'h0) begin
            n_fail++;
            $display("FAIL midrun_async got act=%b col=%b rgb=%h exp 0/0/0", active, col, rgb);
        end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (active !== 4'b0000 || rgb !== 24'h0 || col !== 4'b0000) begin
                n_fail++;
                $display("FAIL midrun_held cyc=%0d got act=%b col=%b rgb=%h", i, active, col, rgb);
            end
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (active !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrun_after got=%b exp=0000", active);
        end
    endtask

    task automatic test_spawn_move();
        int t0;
        do_reset();
        px = 10'd100; py = 10'd400;
        fire_once();
        t0 = n_ticks;
        n_tests++;
        if (active !== 4'b0001) begin
            n_fail++;
            $display("FAIL spawn_slot0 got=%b exp=0001", active);
        end
        x = 19'd100; y = 19'd394;
        step();
        n_tests++;
        if (rgb !== YEL) begin
            n_fail++;
            $display("FAIL spawn_pos got rgb=%h exp=%h", rgb, YEL);
        end
        repeat (3) step();
        fire_once();   // cooldown is 3 here
        n_tests++;
        if (active !== 4'b0001) begin
            n_fail++;
            $display("FAIL cooldown_block got=%b exp=0001", active);
        end
        x = 19'd700; y = 19'd700;
        for (int i = 0; i < 20 && (n_ticks - t0) < 3; i++) step();
        x = 19'd100; y = 19'd382;
        step();
        n_tests++;
        if (rgb !== YEL) begin
            n_fail++;
            $display("FAIL move_3ticks_top got rgb=%h exp=%h", rgb, YEL);
        end
        y = 19'd381;
        step();
        n_tests++;
        if (rgb !== 24'h0) begin
            n_fail++;
            $display("FAIL move_3ticks_above got rgb=%h exp=000000", rgb);
        end
    endtask

    task automatic test_hit();
        do_reset();
        px = 10'd110; py = 10'd56;
        fire_once();
        epos[19:0] = {10'd100, 10'd40};
        n_tests++;
        if (active !== 4'b0001 || col !== 4'b0000) begin
            n_fail++;
            $display("FAIL hit_pre got act=%b col=%b exp 0001/0000", active, col);
        end
        step();
        n_tests++;
        if (col !== 4'b0001 || active[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_pulse got col=%b act=%b exp col=0001 act0=0", col, active);
        end
        step();
        n_tests++;
        if (col !== 4'b0000) begin
            n_fail++;
            $display("FAIL hit_one_cycle got col=%b exp=0000", col);
        end
        edead[0] = 1'b1;
        repeat (8) step();
        fire_once();
        for (int i = 0; i < 8; i++) begin
            step();
            n_tests++;
            if (col !== 4'b0000) begin
                n_fail++;
                $display("FAIL dead_no_pulse cyc=%0d got col=%b exp=0000", i, col);
            end
        end
        x = 19'd110; y = 19'd52;
        step();
        n_tests++;
        if (rgb !== 24'h0 || active[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL dead_moving got rgb=%h act=%b exp rgb=000000 act0=1", rgb, active);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        px = 10'd200; py = 10'd330;
        fire_once();
        repeat (8) step();
        fire_once();
        n_tests++;
        if (active !== 4'b0011) begin
            n_fail++;
            $display("FAIL b2b_two got=%b exp=0011", active);
        end
        epos[39:20] = {10'd190, 10'd300};
        step();
        n_tests++;
        if (col !== 4'b0010 || active !== 4'b0010) begin
            n_fail++;
            $display("FAIL b2b_first got col=%b act=%b exp 0010/0010", col, active);
        end
        step();
        n_tests++;
        if (col !== 4'b0010 || active !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_second got col=%b act=%b exp 0010/0000", col, active);
        end
        step();
        n_tests++;
        if (col !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_done got col=%b exp=0000", col);
        end
    endtask

    task automatic test_full_and_top();
        do_reset();
        px = 10'd50; py = 10'd500;
        for (int i = 0; i < 4; i++) begin
            fire_once();
            repeat (8) step();
        end
        fire_once();
        n_tests++;
        if (active !== 4'b1111) begin
            n_fail++;
            $display("FAIL full_drop got=%b exp=1111", active);
        end
        do_reset();
        px = 10'd50; py = 10'd9;
        fire_once();
        n_tests++;
        if (active !== 4'b0001) begin
            n_fail++;
            $display("FAIL top_spawn got=%b exp=0001", active);
        end
        repeat (4) step();
        n_tests++;
        if (active !== 4'b0000) begin
            n_fail++;
            $display("FAIL top_invalidate got=%b exp=0000", active);
        end
    endtask

    task automatic test_fire_held();
        int cnt;
        do_reset();
        px = 10'd300; py = 10'd600;
        fire = 1'b1;
        repeat (40) step();
        fire = 1'b0;
        cnt = $countones(active);
        n_tests++;
`ifdef PROJ_AUTOFIRE_EN
        if (cnt != 4) begin
            n_fail++;
            $display("FAIL held_spawns got=%0d exp=4", cnt);
        end
`else
        if (cnt != 1) begin
            n_fail++;
            $display("FAIL held_spawns got=%0d exp=1", cnt);
        end
`endif
        n_tests++;
        if (active !== m_active()) begin
            n_fail++;
            $display("FAIL held_model got=%b exp=%b", active, m_active());
        end
    endtask

    task automatic test_random();
        int b;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) begin
                for (int e = 0; e < NE; e++) begin
                    epos[20*e +: 20] = {10'($urandom_range(0, 650)), 10'($urandom_range(0, 470))};
                    edead[e] = ($urandom_range(0, 3) == 0);
                end
            end
            fire = ($urandom_range(0, 2) == 0);
            px   = 10'($urandom_range(0, 639));
            py   = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 10))
                                               : 10'($urandom_range(100, 479));
            if ($urandom_range(0, 1) == 1) begin
                b = $urandom_range(0, NB - 1);
                x = 19'(mbx[b] + $urandom_range(0, 3) - 1);
                y = 19'(mby[b] + $urandom_range(0, 7) - 1);
            end else begin
                x = 19'($urandom);
                y = 19'($urandom_range(0, 600));
            end
            step();
            n_tests++;
            if (active !== m_active()) begin
                n_fail++;
                $display("FAIL rand_active cyc=%0d got=%b exp=%b", c, active, m_active());
            end
            n_tests++;
            if (col !== mcol) begin
                n_fail++;
                $display("FAIL rand_collided cyc=%0d got=%b exp=%b", c, col, mcol);
            end
            n_tests++;
            if (rgb !== mrgb) begin
                n_fail++;
                $display("FAIL rand_rgb cyc=%0d got=%h exp=%h", c, rgb, mrgb);
            end
        end
        fire = 1'b0;
    endtask

    initial begin
        park();
        model_reset();
        test_reset();
        test_spawn_move();
        test_hit();
        test_back_to_back();
        test_full_and_top();
        test_fire_held();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
